// File: rtl/bcd_serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the serial BCD adder controller.
// The master side issues requests; the controller is the slave.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that reuses one single-digit BCD full adder,
// one digit per clock, least-significant digit first. Operands are latched
// on accept, the result and carry are published together with a one-cycle
// done pulse and then held until the next completion.
// Optional feature macro: BCD_DIGIT_CHECK_EN (flags operand digits above 9
// on err; without it err is constant 0).
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_serial_add_ctrl_if.slave bus
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic             load, step, finish;

  logic [W-1:0]     a_reg, b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx_reg;

  logic [3:0]       a_dig, b_dig;
  logic [4:0]       dsum;
  logic [3:0]       digit;
  logic             carry_next;
  logic             last_dig;

  logic [W-1:0]     sum_next;
  logic [W-1:0]     sum_reg;
  logic             cout_reg;
  logic             done_reg;

  assign last_dig = (idx_reg == IDX_W'(DIGITS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and control strobes
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_dig) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shared single-digit BCD full adder: 5-bit binary sum folded back to 0..9
  assign a_dig = a_reg[4*idx_reg +: 4];
  assign b_dig = b_reg[4*idx_reg +: 4];
  assign dsum  = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_reg};

  always_comb begin
    carry_next = (dsum >= 5'd10);
    if (dsum >= 5'd30)      digit = 4'(dsum - 5'd30);
    else if (dsum >= 5'd20) digit = 4'(dsum - 5'd20);
    else if (dsum >= 5'd10) digit = 4'(dsum - 5'd10);
    else                    digit = dsum[3:0];
  end

  // Operand, carry and digit-index registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
    end else if (load) begin
      a_reg     <= bus.a;
      b_reg     <= bus.b;
      carry_reg <= bus.cin;
      idx_reg   <= '0;
    end else if (step) begin
      carry_reg <= carry_next;
      idx_reg   <= idx_reg + IDX_W'(1);
    end
  end

  // Working-sum slots; the top slot is taken straight from the adder since
  // it is produced on the same edge the result is published.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_slot
      if (gi == DIGITS - 1) begin : g_top
        assign sum_next[4*gi +: 4] = digit;
      end else begin : g_low
        logic [3:0] slot_reg;
        // Capture this digit when the index reaches its slot
        always_ff @(posedge clk) begin
          if (!rst_n)                              slot_reg <= 4'd0;
          else if (load)                           slot_reg <= 4'd0;
          else if (step && idx_reg == IDX_W'(gi))  slot_reg <= digit;
        end
        assign sum_next[4*gi +: 4] = slot_reg;
      end
    end
  endgenerate

  // Published result, carry and completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= finish;
      if (finish) begin
        sum_reg  <= sum_next;
        cout_reg <= carry_next;
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic [2*DIGITS-1:0] bad_dig;
  logic                err_pend_reg;
  logic                err_reg;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_chk
      assign bad_dig[gi]          = (bus.a[4*gi +: 4] > 4'd9);
      assign bad_dig[DIGITS + gi] = (bus.b[4*gi +: 4] > 4'd9);
    end
  endgenerate

  // Remember operand validity at accept, publish it with the result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pend_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if (load)   err_pend_reg <= |bad_dig;
      if (finish) err_reg      <= err_pend_reg;
    end
  end

  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy = (state_reg == RUN);
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl with a cycle-level reference model
// that computes sums by decimal arithmetic and checks every cycle.
module tb_bcd_serial_add_ctrl;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) ifc ();

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Decimal addition digit by digit: digit = s mod 10, carry = s >= 10
  function automatic logic [W:0] bcd_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int cc;
    int s;
    logic [W-1:0] r;
    cc = int'(c);
    r  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + cc;
      r[4*i +: 4] = 4'(s % 10);
      cc = (s >= 10) ? 1 : 0;
    end
    return {cc[0], r};
  endfunction

  function automatic logic has_bad(input logic [W-1:0] x, input logic [W-1:0] y);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Reference model, advanced on each rising edge from the sampled inputs
  logic         m_valid = 1'b0;
  logic         m_run   = 1'b0;
  int           m_cnt   = 0;
  logic         m_done  = 1'b0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic         m_err   = 1'b0;
  logic [W:0]   m_pend  = '0;
  logic         m_pend_err = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1;
      m_run   = 1'b0;
      m_cnt   = 0;
      m_done  = 1'b0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_err   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_run) begin
        m_cnt++;
        if (m_cnt == DIGITS) begin
          m_run  = 1'b0;
          m_done = 1'b1;
          {m_cout, m_sum} = m_pend;
          m_err  = m_pend_err;
        end
      end else if (ifc.start) begin
        m_pend = bcd_add(ifc.a, ifc.b, ifc.cin);
`ifdef BCD_DIGIT_CHECK_EN
        m_pend_err = has_bad(ifc.a, ifc.b);
`else
        m_pend_err = 1'b0;
`endif
        m_run = 1'b1;
        m_cnt = 0;
      end
    end
  end

  // Compare DUT against the model on every falling edge once reset was seen
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", ifc.busy, m_run);
      chk("done", ifc.done, m_done);
      chk("sum",  ifc.sum,  m_sum);
      chk("cout", ifc.cout, m_cout);
      chk("err",  ifc.err,  m_err);
      if (ifc.done) done_cnt++;
    end
  end

  // One run; bb=1 means we are already sitting in the previous done cycle
  task automatic do_run(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic [W-1:0] esum, input logic ecout, input bit bb,
                        input string nm);
    int n;
    int busy_n;
    if (!bb) @(negedge clk);
    ifc.start = 1'b1; ifc.a = ta; ifc.b = tb_; ifc.cin = tc;
    @(negedge clk);
    ifc.start = 1'b0;
    n = 1;
    busy_n = 0;
    while (!ifc.done && n < 20) begin
      if (ifc.busy) busy_n++;
      @(negedge clk);
      n++;
    end
    $display("run %s a=%h b=%h cin=%0d -> sum=%h cout=%0d done_after=%0d busy_cycles=%0d",
             nm, ta, tb_, tc, ifc.sum, ifc.cout, n, busy_n);
    chk({nm, "_latency"}, n, DIGITS + 1);
    chk({nm, "_busy_len"}, busy_n, DIGITS);
    chk({nm, "_sum_lit"}, ifc.sum, esum);
    chk({nm, "_cout_lit"}, ifc.cout, ecout);
  endtask

  initial begin
    int d0;
    int n;
    ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_busy", ifc.busy, 1'b0);
    chk("reset_sum",  ifc.sum,  16'h0000);

    // Model pinned by hand-computed literals
    chk("model_6912", bcd_add(16'h1234, 16'h5678, 1'b0), 17'h0_6912);
    chk("model_19999", bcd_add(16'h9999, 16'h9999, 1'b1), 17'h1_9999);

    do_run(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, "basic");
    do_run(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
    do_run(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, "max");
    do_run(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, "b2b_zero");

    // Start while busy and mid-run operand change are ignored
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = 16'h1111; ifc.b = 16'h2222; ifc.cin = 1'b0;
    @(negedge clk);
    ifc.start = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = 16'h4444; ifc.b = 16'h4444; ifc.cin = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0; ifc.a = 16'h8888;
    n = 0;
    while (!ifc.done && n < 20) begin @(negedge clk); n++; end
    $display("run ignore a=1111 b=2222 -> sum=%h cout=%0d", ifc.sum, ifc.cout);
    chk("ignore_sum_lit", ifc.sum, 16'h3333);
    repeat (6) @(negedge clk);
    chk("ignore_one_done", done_cnt - d0, 1);

    // Reset in the middle of a run
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = 16'h5555; ifc.b = 16'h4444;
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("run midreset -> busy=%0d done=%0d sum=%h cout=%0d",
             ifc.busy, ifc.done, ifc.sum, ifc.cout);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_done", ifc.done, 1'b0);
    chk("rst_sum",  ifc.sum,  16'h0000);
    chk("rst_cout", ifc.cout, 1'b0);
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);

    // Invalid digit followed by a valid run
    do_run(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b0, "baddigit");
`ifdef BCD_DIGIT_CHECK_EN
    chk("err_set_lit", ifc.err, 1'b1);
`else
    chk("err_set_lit", ifc.err, 1'b0);
`endif
    do_run(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "valid");
    chk("err_clr_lit", ifc.err, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Multi-digit BCD adder controller that runs a `DIGITS`-wide packed-BCD addition through one shared single-digit BCD full-add datapath, one digit per cycle, least-significant digit first. It accepts a start request, steps through the digits while propagating the decimal carry, then presents the full result with a one-cycle `done` pulse. It sits between calculator/display control logic and the single-digit BCD adder, so wide decimal sums cost one digit adder instead of `DIGITS` adders.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand (≥1).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; accepted only when `busy`=0.
- `a`  in  4*DIGITS  operand A, packed BCD, digit i at bits [4i+3:4i].
- `b`  in  4*DIGITS  operand B, same packing.
- `cin`  in  1  carry into digit 0.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse: `sum`/`cout` valid from this cycle on.
- `sum`  out  4*DIGITS  result, packed BCD.
- `cout`  out  1  decimal carry out of the top digit.
- `err`  out  1  invalid-digit flag (see Configuration).

## Operation
- States: IDLE, RUN. Reset (`rst_n`=0 at an edge) forces IDLE, digit index 0, working carry 0, `busy`=0, `done`=0, `sum`=0, `cout`=0, `err`=0, regardless of current state.
- IDLE + `start`=1: latch `a`, `b`, `cin` into operand/carry registers; clear working sum; index ← 0; go to RUN.
- RUN, each edge: digit adder computes s = {0,a_i} + {0,b_i} + carry (5-bit); digit = s mod 10; carry_next = (s ≥ 10). Write digit into working-sum slot index; carry ← carry_next; index ← index+1.
- On the edge that processes digit DIGITS−1: copy working sum to `sum`, final carry to `cout`, pulse `done`, return to IDLE.
- `sum`/`cout`/`err` are updated only at completion; they hold the last result (stable) through later runs until the next completion.
- `start` while `busy`=1 is ignored; input changes during RUN have no effect (operands are latched).
- Inputs with digits >9: arithmetic rule above still applies (digit always 0–9, carry 1 bit); result is not meaningful BCD.

## Timing
- `start` sampled high at edge T0 (with `busy`=0) → `busy`=1 from T0 until edge T0+DIGITS.
- Digits processed at edges T0+1 … T0+DIGITS; `done`=1 for exactly the cycle after edge T0+DIGITS; `busy`=0 in that same cycle.
- Latency start→done: DIGITS+1 cycles; throughput one addition per DIGITS+1 cycles.
- `start` high in the `done` cycle is accepted (back-to-back runs, no idle gap).
- Reset asserted mid-run: run abandoned, no `done`, outputs zero next cycle.

## Configuration
- `BCD_DIGIT_CHECK_EN` defined: operands are checked at accept; any digit of `a` or `b` >9 sets a sticky internal flag, presented on `err` together with `done` and held until the next completion; a valid run clears it.
- Not defined: no check logic; `err` tied to 0.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start pulse → `done` 5 cycles after accept edge, sum=0x6912, cout=0, `busy` high exactly 4 cycles.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1 (carry ripples through all digits).
- a=0x9999, b=0x9999, cin=1 → sum=0x9999, cout=1; immediately restart in `done` cycle with a=0x0000, b=0x0000, cin=0 → sum=0x0000, cout=0 after 5 more cycles.
- Start a run, pulse `start` again with different operands and change `a` mid-run → ignored, result matches first latched operands; exactly one `done`.
- Assert `rst_n`=0 at cycle 2 of a run → `busy`, `done`, `sum`, `cout` all 0 next cycle; no `done` afterwards until a new start.
- With `BCD_DIGIT_CHECK_EN`: a=0x00A0, b=0x0000 → `err`=1 at `done`; following run a=0x0001, b=0x0001 → sum=0x0002, `err`=0. Without macro: `err` stays 0.
